s_reg_file: RTL and testbench

Parametrised scalar register file for the vector/scalar datapath. It provides two independent registered read ports, one byte-lane-masked write port, and write-to-read bypass. A per-register pending scoreboard lets the issue logic mark a register as awaiting a long-latency result and detect read hazards against it. It sits between the instruction decode stage and the scalar ALU/load unit, replacing the fixed 8×16 scalar bank.

---
 rtl/s_reg_file.sv | 123 ++++++++++++
 tb/tb_s_reg_file.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/s_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : s_reg_file
// Description : Scalar register file with two registered read ports,
//               byte-masked write port, write-to-read bypass and pending
//               scoreboard.
// Revision    : 1.0
// ============================================================================
module s_reg_file #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [AW-1:0]      RdAddrA,
  input  logic               RD_A,
  output logic [WIDTH-1:0]   DataOutA,
  output logic               ValidA,
  output logic               HazardA,
  input  logic [AW-1:0]      RdAddrB,
  input  logic               RD_B,
  output logic [WIDTH-1:0]   DataOutB,
  output logic               ValidB,
  output logic               HazardB,
  input  logic [AW-1:0]      WrAddr,
  input  logic [WIDTH/8-1:0] WrBe,
  input  logic [WIDTH-1:0]   DataIn,
  input  logic               LockReq,
  input  logic [AW-1:0]      LockAddr,
  output logic [DEPTH-1:0]   PendingVec
);

  localparam int c_NBYTES = WIDTH / 8;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_pend;

  logic [WIDTH-1:0] r_dout_a, r_dout_b;
  logic             r_valid_a, r_valid_b;

  logic [WIDTH-1:0] w_mem_a, w_mem_b;
  logic [WIDTH-1:0] w_data_a, w_data_b;
  logic             w_pend_a, w_pend_b;
  logic             w_hit_a, w_hit_b;
  logic             w_wr_any;

  assign w_wr_any = |WrBe;

  // Loop-based decode: addresses at or above DEPTH never match, so they read
  // as zero, are never pending, and are ignored by writes and locks.
  always_comb begin
    w_mem_a  = '0;
    w_mem_b  = '0;
    w_pend_a = 1'b0;
    w_pend_b = 1'b0;
    w_hit_a  = 1'b0;
    w_hit_b  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RdAddrA == AW'(i)) begin
        w_mem_a  = r_mem[i];
        w_pend_a = r_pend[i];
        w_hit_a  = (WrAddr == RdAddrA);
      end
      if (RdAddrB == AW'(i)) begin
        w_mem_b  = r_mem[i];
        w_pend_b = r_pend[i];
        w_hit_b  = (WrAddr == RdAddrB);
      end
    end
  end

  // Per-lane bypass of the same-cycle write into each read path.
  always_comb begin
    w_data_a = w_mem_a;
    w_data_b = w_mem_b;
    for (int b = 0; b < c_NBYTES; b++) begin
      if (w_hit_a && WrBe[b]) w_data_a[8*b +: 8] = DataIn[8*b +: 8];
      if (w_hit_b && WrBe[b]) w_data_b[8*b +: 8] = DataIn[8*b +: 8];
    end
  end

  assign HazardA = RD_A & w_pend_a;
  assign HazardB = RD_B & w_pend_b;

  // Lock is applied after the write clear so that a same-cycle lock wins.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_pend <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int b = 0; b < c_NBYTES; b++) begin
          if (WrAddr == AW'(i) && WrBe[b]) r_mem[i][8*b +: 8] <= DataIn[8*b +: 8];
        end
        if (WrAddr == AW'(i) && w_wr_any) r_pend[i] <= 1'b0;
        if (LockReq && LockAddr == AW'(i)) r_pend[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_dout_a  <= '0;
      r_dout_b  <= '0;
      r_valid_a <= 1'b0;
      r_valid_b <= 1'b0;
    end else begin
      r_valid_a <= RD_A && !w_pend_a;
      r_valid_b <= RD_B && !w_pend_b;
      if (RD_A && !w_pend_a) r_dout_a <= w_data_a;
      if (RD_B && !w_pend_b) r_dout_b <= w_data_b;
    end
  end

  assign DataOutA   = r_dout_a;
  assign DataOutB   = r_dout_b;
  assign ValidA     = r_valid_a;
  assign ValidB     = r_valid_b;
  assign PendingVec = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_s_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_s_reg_file
// Description : Directed self-checking bench for s_reg_file (DEPTH 8 and 6).
// Revision    : 1.0
// ============================================================================
module tb_s_reg_file;

  logic        Clk, Rst;
  logic [2:0]  RdAddrA, RdAddrB, WrAddr, LockAddr;
  logic        RD_A, RD_B, LockReq;
  logic [1:0]  WrBe;
  logic [15:0] DataIn;

  logic [15:0] DataOutA, DataOutB, DataOutA6, DataOutB6;
  logic        ValidA, ValidB, HazardA, HazardB;
  logic        ValidA6, ValidB6, HazardA6, HazardB6;
  logic [7:0]  PendingVec;
  logic [5:0]  PendingVec6;

  int n_cmp = 0;
  int n_err = 0;

  s_reg_file #(.WIDTH(16), .DEPTH(8), .AW(3)) dut (
    .Clk(Clk), .Rst(Rst),
    .RdAddrA(RdAddrA), .RD_A(RD_A), .DataOutA(DataOutA), .ValidA(ValidA), .HazardA(HazardA),
    .RdAddrB(RdAddrB), .RD_B(RD_B), .DataOutB(DataOutB), .ValidB(ValidB), .HazardB(HazardB),
    .WrAddr(WrAddr), .WrBe(WrBe), .DataIn(DataIn),
    .LockReq(LockReq), .LockAddr(LockAddr), .PendingVec(PendingVec)
  );

  s_reg_file #(.WIDTH(16), .DEPTH(6), .AW(3)) dut6 (
    .Clk(Clk), .Rst(Rst),
    .RdAddrA(RdAddrA), .RD_A(RD_A), .DataOutA(DataOutA6), .ValidA(ValidA6), .HazardA(HazardA6),
    .RdAddrB(RdAddrB), .RD_B(RD_B), .DataOutB(DataOutB6), .ValidB(ValidB6), .HazardB(HazardB6),
    .WrAddr(WrAddr), .WrBe(WrBe), .DataIn(DataIn),
    .LockReq(LockReq), .LockAddr(LockAddr), .PendingVec(PendingVec6)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b1; RD_A = 1'b0; RD_B = 1'b0; RdAddrA = '0; RdAddrB = '0;
    WrAddr = '0; WrBe = '0; DataIn = '0; LockReq = 1'b0; LockAddr = '0;
    #11;
    chk("rst_douta", 32'(DataOutA), 32'h0);
    chk("rst_valida", 32'(ValidA), 32'h0);
    chk("rst_validb", 32'(ValidB), 32'h0);
    chk("rst_pend", 32'(PendingVec), 32'h0);
    Rst = 1'b0;

    // Read every address on both ports after reset
    for (int a = 0; a < 8; a++) begin
      RD_A = 1'b1; RD_B = 1'b1; RdAddrA = 3'(a); RdAddrB = 3'(7 - a);
      tick();
      chk("rdall_a", {15'h0, ValidA, DataOutA}, {15'h0, 1'b1, 16'h0000});
      chk("rdall_b", {15'h0, ValidB, DataOutB}, {15'h0, 1'b1, 16'h0000});
    end

    // Byte-lane masked writes to r3
    RD_A = 1'b0; RD_B = 1'b0;
    WrAddr = 3'd3; DataIn = 16'hBEEF; WrBe = 2'b11;
    tick();
    chk("idle_valida", 32'(ValidA), 32'h0);
    chk("idle_hold_a", 32'(DataOutA), 32'h0000);
    DataIn = 16'h1234; WrBe = 2'b10;
    tick();
    WrBe = 2'b00; RD_A = 1'b1; RdAddrA = 3'd3;
    tick();
    chk("mask_r3", {15'h0, ValidA, DataOutA}, {15'h0, 1'b1, 16'h12EF});

    // Same-cycle write and dual read of r5 (bypass)
    RD_B = 1'b1; RdAddrA = 3'd5; RdAddrB = 3'd5;
    WrAddr = 3'd5; DataIn = 16'hA5A5; WrBe = 2'b11;
    tick();
    chk("byp_a", {15'h0, ValidA, DataOutA}, {15'h0, 1'b1, 16'hA5A5});
    chk("byp_b", {15'h0, ValidB, DataOutB}, {15'h0, 1'b1, 16'hA5A5});

    // Lock r2, then hazard, then clearing write, then accepted read
    WrBe = 2'b00; RD_A = 1'b0; RD_B = 1'b0; LockReq = 1'b1; LockAddr = 3'd2;
    tick();
    chk("lock_pend", 32'(PendingVec), 32'h04);
    LockReq = 1'b0; RD_A = 1'b1; RdAddrA = 3'd2;
    #1;
    chk("haz_a", 32'(HazardA), 32'h1);
    chk("haz_b_idle", 32'(HazardB), 32'h0);
    tick();
    chk("haz_hold", {15'h0, ValidA, DataOutA}, {15'h0, 1'b0, 16'hA5A5});
    WrAddr = 3'd2; DataIn = 16'h0042; WrBe = 2'b11;
    #1;
    chk("haz_during_clr", 32'(HazardA), 32'h1);
    tick();
    chk("clr_same_cyc", {15'h0, ValidA, DataOutA}, {15'h0, 1'b0, 16'hA5A5});
    chk("clr_pend", 32'(PendingVec), 32'h00);
    WrBe = 2'b00;
    #1;
    chk("haz_cleared", 32'(HazardA), 32'h0);
    tick();
    chk("rd_r2", {15'h0, ValidA, DataOutA}, {15'h0, 1'b1, 16'h0042});

    // Lock and write r6 together: lock wins, data stored
    RD_A = 1'b0; LockReq = 1'b1; LockAddr = 3'd6;
    WrAddr = 3'd6; DataIn = 16'h6666; WrBe = 2'b11;
    tick();
    chk("lockwr_pend", 32'(PendingVec), 32'h40);
    LockReq = 1'b0; WrBe = 2'b00; DataIn = 16'hFFFF;
    tick();
    chk("be0_noclr", 32'(PendingVec), 32'h40);
    DataIn = 16'h0077; WrBe = 2'b01;
    tick();
    chk("be01_clr", 32'(PendingVec), 32'h00);
    WrBe = 2'b00; RD_A = 1'b1; RdAddrA = 3'd6;
    tick();
    chk("rd_r6", {15'h0, ValidA, DataOutA}, {15'h0, 1'b1, 16'h6677});

    // Address 7: real register in DEPTH=8, out of range in DEPTH=6
    RD_A = 1'b1; RD_B = 1'b1; RdAddrA = 3'd7; RdAddrB = 3'd5;
    WrAddr = 3'd7; DataIn = 16'h7777; WrBe = 2'b11; LockReq = 1'b1; LockAddr = 3'd7;
    #1;
    chk("oor_haz6", 32'(HazardA6), 32'h0);
    tick();
    chk("oor_rd6", {15'h0, ValidA6, DataOutA6}, {15'h0, 1'b1, 16'h0000});
    chk("rd6_r5", {15'h0, ValidB6, DataOutB6}, {15'h0, 1'b1, 16'hA5A5});
    chk("oor_pend6", 32'(PendingVec6), 32'h00);
    chk("r7_byp8", {15'h0, ValidA, DataOutA}, {15'h0, 1'b1, 16'h7777});
    chk("r7_pend8", 32'(PendingVec), 32'h80);
    LockReq = 1'b0; WrBe = 2'b00;
    #1;
    chk("r7_haz8", 32'(HazardA), 32'h1);
    chk("oor_haz6b", 32'(HazardA6), 32'h0);
    tick();
    chk("oor_rd6b", {15'h0, ValidA6, DataOutA6}, {15'h0, 1'b1, 16'h0000});
    chk("r7_blk8", 32'(ValidA), 32'h0);

    // Mid-cycle asynchronous reset
    RD_A = 1'b0; RD_B = 1'b0; WrAddr = 3'd1; DataIn = 16'h1111; WrBe = 2'b11;
    tick();
    WrBe = 2'b00; RD_A = 1'b1; RdAddrA = 3'd1;
    tick();
    chk("pre_rst_r1", {15'h0, ValidA, DataOutA}, {15'h0, 1'b1, 16'h1111});
    #1 Rst = 1'b1;
    #1;
    chk("arst_douta", 32'(DataOutA), 32'h0);
    chk("arst_valida", 32'(ValidA), 32'h0);
    chk("arst_pend", 32'(PendingVec), 32'h00);
    #1 Rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      RD_A = 1'b1; RD_B = 1'b1; RdAddrA = 3'(a); RdAddrB = 3'(7 - a);
      tick();
      chk("post_rst_a", {15'h0, ValidA, DataOutA}, {15'h0, 1'b1, 16'h0000});
      chk("post_rst_b", {15'h0, ValidB, DataOutB}, {15'h0, 1'b1, 16'h0000});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
